mem_req_bridge: RTL and testbench
=================================

MEM_REQ_BRIDGE -- requirements
Module: mem_req_bridge

Interface
REQ-001 SHALL have parameter ERR_ON_MISALIGN, default 1: 1 = reject non-word-aligned requests locally; 0 = forward them with addr[1:0] forced to 0.
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  CPU load/store request valid.
REQ-005 SHALL have port req_ready  out  1  bridge can accept a request.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data.
REQ-009 SHALL have port req_wstrb  in  4  store byte enables.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  out  32  load data, valid with resp_valid.
REQ-012 SHALL have port resp_err  out  1  error flag, valid with resp_valid.
REQ-013 SHALL have port m_axi_araddr  out  32  read address to cache.
REQ-014 SHALL have port m_axi_arvalid  out  1  read address valid.
REQ-015 SHALL have port m_axi_arready  in  1  read address accepted.
REQ-016 SHALL have port m_axi_rdata  in  32  read data.
REQ-017 SHALL have port m_axi_rresp  in  2  read response.
REQ-018 SHALL have port m_axi_rvalid  in  1  read data valid.
REQ-019 SHALL have port m_axi_rready  out  1  read data accept.
REQ-020 SHALL have port m_axi_awaddr  out  32  write address.
REQ-021 SHALL have port m_axi_awvalid  out  1  write address valid.
REQ-022 SHALL have port m_axi_awready  in  1  write address accepted.
REQ-023 SHALL have port m_axi_wdata  out  32  write data.
REQ-024 SHALL have port m_axi_wstrb  out  4  write strobes.
REQ-025 SHALL have port m_axi_wvalid  out  1  write data valid.
REQ-026 SHALL have port m_axi_wready  in  1  write data accepted.
REQ-027 SHALL have port m_axi_bresp  in  2  write response.
REQ-028 SHALL have port m_axi_bvalid  in  1  write response valid.
REQ-029 SHALL have port m_axi_bready  out  1  write response accept.

Function
REQ-030 SHALL implement FSM IDLE, AR, R, WR (AW+W), B, RESP; exactly one transaction outstanding; req_ready registered, 1 only in IDLE.
REQ-031 SHALL, on req_valid&&req_ready, latch addr/wdata/wstrb/we; go to AR (load) or WR (store) next cycle; misaligned with ERR_ON_MISALIGN=1 goes to RESP with err=1, no AXI traffic.
REQ-032 SHALL in AR hold arvalid=1 and araddr stable until arready sampled high, then go to R with rready=1 next cycle.
REQ-033 SHALL in R, on rvalid, drop rready, capture rdata into resp_rdata, err=rresp[1], go to RESP.
REQ-034 SHALL in WR assert awvalid and wvalid together, clearing each independently on its own ready; both done in same or different cycles -> B with bready=1 next cycle.
REQ-035 SHALL in B, on bvalid, drop bready, err=bresp[1], resp_rdata unchanged, go to RESP.
REQ-036 SHALL in RESP pulse resp_valid for exactly one cycle (no backpressure), then return to IDLE; minimum request-to-resp_valid latency 4 cycles with ready slaves.
REQ-037 SHALL never drop a valid before its handshake, never change AXI payload while valid is high, and keep stores with req_wstrb=0 as normal AXI writes.

Reset
REQ-038 SHALL, while rstn=0 (asynchronously, including mid-transaction), force state IDLE and req_ready, resp_valid, resp_err, all AXI valid/ready outputs to 0; addresses, data, strobes to 0; req_ready=1 first cycle after release.

Structure
REQ-039 SHALL place the FSM state enum and resp codes (OKAY=2'b00, SLVERR=2'b10) in shared package mem_bridge_pkg; single module, no sub-module.

Verification
REQ-040 SHALL cover load 0x0000_1004, arready after 3 cycles, rdata 0xDEADBEEF rresp 0 -> one resp_valid, rdata 0xDEADBEEF, err 0.
REQ-041 SHALL cover store 0x0010_0040 data 0x12345678 strb 0x3, awready 2 cycles before wready -> awvalid/wvalid drop independently, single resp_valid err 0.
REQ-042 SHALL cover bresp=2'b10 on store -> resp_err=1; rresp=2'b10 on load -> resp_err=1.
REQ-043 SHALL cover load 0x0000_0002, ERR_ON_MISALIGN=1 -> resp_err=1, no arvalid ever; ERR_ON_MISALIGN=0 -> araddr 0x0000_0000.
REQ-044 SHALL cover rstn low while arvalid=1 -> arvalid, req_ready 0 immediately; back-to-back requests after release accepted one at a time.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared FSM state and AXI response codes for mem_req_bridge
package mem_bridge_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic resp_is_err(input logic [1:0] resp);
    return !(resp inside {RESP_OKAY, RESP_EXOKAY});
  endfunction
endpackage

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: single-outstanding CPU load/store to AXI4-Lite master bridge
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);
  state_t      r_state;
  logic        r_req_ready, r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata, r_araddr, r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic        w_misalign, w_aw_done, w_w_done;
  logic [31:0] w_addr;
  assign w_misalign = |req_addr[1:0];
  assign w_addr     = {req_addr[31:2], 2'b00};
  assign w_aw_done  = !r_awvalid || m_axi_awready;
  assign w_w_done   = !r_wvalid || m_axi_wready;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE:
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            if (ERR_ON_MISALIGN && w_misalign) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_we) begin
              r_state   <= S_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= w_addr;
              r_wdata   <= req_wdata;
              r_wstrb   <= req_wstrb;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_addr;
            end
          end else r_req_ready <= 1'b1;
        S_AR:
          if (m_axi_arready) begin
            r_state   <= S_R;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        S_R:
          if (m_axi_rvalid) begin
            r_state      <= S_RESP;
            r_rready     <= 1'b0;
            r_resp_rdata <= m_axi_rdata;
            r_resp_err   <= resp_is_err(m_axi_rresp);
            r_resp_valid <= 1'b1;
          end
        S_WR: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready) r_wvalid <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_state  <= S_B;
            r_bready <= 1'b1;
          end
        end
        S_B:
          if (m_axi_bvalid) begin
            r_state      <= S_RESP;
            r_bready     <= 1'b0;
            r_resp_err   <= resp_is_err(m_axi_bresp);
            r_resp_valid <= 1'b1;
          end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
endmodule

// File: tb/tb_mem_req_bridge.sv
// tb_mem_req_bridge: directed self-checking bench for mem_req_bridge
module tb_mem_req_bridge;
  import mem_bridge_pkg::*;
  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_valid0 = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rdata = '0;
  logic [3:0] req_wstrb = '0;
  logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] rresp = RESP_OKAY, bresp = RESP_OKAY;
  logic req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] resp_rdata, araddr, awaddr, wdata;
  logic [3:0] wstrb;
  logic z_req_ready, z_resp_valid, z_resp_err, z_arvalid, z_rready, z_awvalid, z_wvalid, z_bready;
  logic [31:0] z_resp_rdata, z_araddr, z_awaddr, z_wdata;
  logic [3:0] z_wstrb;
  int n_cmp = 0, n_err = 0, arv_cnt = 0, rsp_cnt = 0, base;

  mem_req_bridge dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready));

  mem_req_bridge #(.ERR_ON_MISALIGN(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid0), .req_ready(z_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(z_resp_valid),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .m_axi_araddr(z_araddr), .m_axi_arvalid(z_arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(z_rready), .m_axi_awaddr(z_awaddr), .m_axi_awvalid(z_awvalid), .m_axi_awready(awready),
    .m_axi_wdata(z_wdata), .m_axi_wstrb(z_wstrb), .m_axi_wvalid(z_wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(z_bready));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid) arv_cnt++;
    if (resp_valid) rsp_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
    req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_rdata", resp_rdata, 0);
    rstn = 1'b1;
    tick();
    chk("rel_req_ready", {31'd0, req_ready}, 1);
    // load with arready three cycles into AR
    base = rsp_cnt;
    req(1'b0, 32'h0000_1004, 0, 0);
    chk("ld_arvalid", {31'd0, arvalid}, 1);
    chk("ld_araddr", araddr, 32'h0000_1004);
    chk("ld_req_ready", {31'd0, req_ready}, 0);
    tick(); tick();
    chk("ld_arvalid_hold", {31'd0, arvalid}, 1);
    chk("ld_araddr_hold", araddr, 32'h0000_1004);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("ld_r_state", {30'd0, arvalid, rready}, 32'b01);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = RESP_OKAY;
    tick();
    rvalid = 1'b0;
    chk("ld_resp", {30'd0, resp_valid, resp_err}, 32'b10);
    chk("ld_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("ld_rready_drop", {31'd0, rready}, 0);
    tick();
    chk("ld_pulse_end", {30'd0, resp_valid, req_ready}, 32'b01);
    chk("ld_pulse_cnt", rsp_cnt - base, 1);
    // store with awready two cycles before wready
    base = rsp_cnt;
    req(1'b1, 32'h0010_0040, 32'h1234_5678, 4'h3);
    chk("st_valids", {30'd0, awvalid, wvalid}, 32'b11);
    chk("st_awaddr", awaddr, 32'h0010_0040);
    chk("st_wdata", wdata, 32'h1234_5678);
    chk("st_wstrb", {28'd0, wstrb}, 3);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("st_aw_drop", {30'd0, awvalid, wvalid}, 32'b01);
    tick();
    chk("st_w_hold", {29'd0, awvalid, wvalid, bready}, 32'b010);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("st_b_state", {29'd0, awvalid, wvalid, bready}, 32'b001);
    bvalid = 1'b1; bresp = RESP_OKAY;
    tick();
    bvalid = 1'b0;
    chk("st_resp", {29'd0, resp_valid, resp_err, bready}, 32'b100);
    chk("st_rdata_keep", resp_rdata, 32'hDEAD_BEEF);
    tick();
    chk("st_pulse_cnt", rsp_cnt - base, 1);
    // store with SLVERR, both readies together
    req(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 4'h0);
    chk("ste_wstrb0", {28'd0, wstrb}, 0);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("ste_b_state", {29'd0, awvalid, wvalid, bready}, 32'b001);
    bvalid = 1'b1; bresp = RESP_SLVERR;
    tick();
    bvalid = 1'b0; bresp = RESP_OKAY;
    chk("ste_err", {30'd0, resp_valid, resp_err}, 32'b11);
    tick();
    // load with SLVERR
    req(1'b0, 32'h0000_0020, 0, 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = RESP_SLVERR;
    tick();
    rvalid = 1'b0; rresp = RESP_OKAY;
    chk("lde_err", {30'd0, resp_valid, resp_err}, 32'b11);
    chk("lde_rdata", resp_rdata, 32'hCAFE_F00D);
    tick();
    // misaligned load rejected locally
    base = arv_cnt;
    req(1'b0, 32'h0000_0002, 0, 0);
    chk("mis_resp", {29'd0, resp_valid, resp_err, arvalid}, 32'b110);
    tick();
    chk("mis_idle", {30'd0, resp_valid, req_ready}, 32'b01);
    chk("mis_no_ar", arv_cnt - base, 0);
    // misaligned load forwarded with low bits cleared
    req_we = 1'b0; req_addr = 32'h0000_0002; req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    chk("mis0_arvalid", {31'd0, z_arvalid}, 1);
    chk("mis0_araddr", z_araddr, 32'h0000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    rvalid = 1'b0;
    chk("mis0_resp", {30'd0, z_resp_valid, z_resp_err}, 32'b10);
    chk("dut_idle_during_mis0", {30'd0, arvalid, resp_valid}, 0);
    tick();
    // asynchronous reset while arvalid is high
    req(1'b0, 32'h0000_0100, 0, 0);
    chk("rstmid_arvalid", {31'd0, arvalid}, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_async", {30'd0, arvalid, req_ready}, 0);
    chk("rstmid_araddr", araddr, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("rstmid_ready", {31'd0, req_ready}, 1);
    // back-to-back requests accepted one at a time
    req_we = 1'b0; req_addr = 32'h0000_0200; req_valid = 1'b1;
    tick();
    req_addr = 32'h0000_0300;
    chk("b2b_busy", {31'd0, req_ready}, 0);
    chk("b2b_a1", araddr, 32'h0000_0200);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick();
    rvalid = 1'b0;
    chk("b2b_r1", resp_rdata, 32'h1111_1111);
    chk("b2b_r1_busy", {30'd0, resp_valid, req_ready}, 32'b10);
    tick();
    chk("b2b_ready2", {31'd0, req_ready}, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_a2", araddr, 32'h0000_0300);
    chk("b2b_a2_state", {30'd0, arvalid, req_ready}, 32'b10);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h2222_2222;
    tick();
    rvalid = 1'b0;
    chk("b2b_r2", resp_rdata, 32'h2222_2222);
    tick();
    chk("b2b_done", {30'd0, resp_valid, req_ready}, 32'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
